// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master (i2c_ctrl) between NUM_REQ register-access requesters.
// Optional BUSY watchdog compiled in with `define SCCB_TIMEOUT_EN.
module sccb_arbiter #(
  parameter int          NUM_REQ     = 3,
  parameter logic        ADDR_NUM    = 1'b1,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ*16-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [7:0]            rdata,
  output logic                  busy,
  output logic                  i2c_start,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [15:0]           byte_addr,
  output logic [7:0]            wr_data,
  output logic                  addr_num,
  input  logic                  i2c_end,
  input  logic [7:0]            rd_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_win;
  logic                 r_start;
  logic                 r_wr;
  logic                 r_rd;
  logic                 r_err;
  logic [NUM_REQ-1:0]   r_ack;
  logic [15:0]          r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_rdata;
  logic [PW-1:0]        w_pick;
`ifdef SCCB_TIMEOUT_EN
  logic [15:0]          r_wdt;
`endif

  // First requester after ptr, wrapping modulo NUM_REQ; ptr itself is ranked last.
  function automatic logic [PW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] req_v,
                                              input logic [PW-1:0]      ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_v[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick = f_rr_pick(req, r_ptr);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_win   <= '0;
      r_start <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef SCCB_TIMEOUT_EN
      r_wdt   <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_win   <= w_pick;
            r_ptr   <= w_pick;
            r_addr  <= req_addr[16*w_pick +: 16];
            r_wdata <= req_wdata[8*w_pick +: 8];
            r_rd    <= req_rd[w_pick];
            r_wr    <= ~req_rd[w_pick];
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
`ifdef SCCB_TIMEOUT_EN
          r_wdt   <= '0;
`endif
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          // A completion in the same cycle as watchdog expiry wins.
          if (i2c_end) begin
            if (r_rd) r_rdata <= rd_data;
            r_err   <= 1'b0;
            r_ack   <= NUM_REQ'(1) << r_win;
            r_state <= S_DONE;
          end
`ifdef SCCB_TIMEOUT_EN
          else if (r_wdt == TIMEOUT_CYC - 16'd1) begin
            r_err   <= 1'b1;
            r_ack   <= NUM_REQ'(1) << r_win;
            r_state <= S_DONE;
          end else begin
            r_wdt <= r_wdt + 16'd1;
          end
`endif
        end
        S_DONE: begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = (r_state != S_IDLE);
  assign i2c_start = r_start;
  assign wr_en     = r_wr;
  assign rd_en     = r_rd;
  assign byte_addr = r_addr;
  assign wr_data   = r_wdata;
  assign addr_num  = ADDR_NUM;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Randomized self-checking bench for sccb_arbiter: transaction-level round-robin model
// plus a behavioural i2c_ctrl responder.
module tb_sccb_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   req_rd;
  logic [N*16-1:0] req_addr;
  logic [N*8-1:0] req_wdata;
  logic [N-1:0]   ack;
  logic           err;
  logic [7:0]     rdata;
  logic           busy;
  logic           i2c_start;
  logic           wr_en;
  logic           rd_en;
  logic [15:0]    byte_addr;
  logic [7:0]     wr_data;
  logic           addr_num;
  logic           i2c_end;
  logic [7:0]     rd_data;

  always #5 clk = ~clk;

  sccb_arbiter #(.NUM_REQ(N), .ADDR_NUM(1'b1), .TIMEOUT_CYC(16'd100)) dut (
    .sys_clk(clk), .sys_rst(rst), .req(req), .req_rd(req_rd), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .i2c_start(i2c_start), .wr_en(wr_en), .rd_en(rd_en), .byte_addr(byte_addr),
    .wr_data(wr_data), .addr_num(addr_num), .i2c_end(i2c_end), .rd_data(rd_data)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending requests with their captured commands, last grant, last read data.
  bit          m_pend[N];
  bit          m_rd[N];
  logic [15:0] m_addr[N];
  logic [7:0]  m_wd[N];
  int          m_ptr;
  logic [7:0]  m_rdata;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post_req(input int i, input bit rd, input logic [15:0] a, input logic [7:0] d);
    req[i]              = 1'b1;
    req_rd[i]           = rd;
    req_addr[16*i +: 16] = a;
    req_wdata[8*i +: 8] = d;
    m_pend[i] = 1'b1;
    m_rd[i]   = rd;
    m_addr[i] = a;
    m_wd[i]   = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = N - 1;
    req   = '0;
  endtask

  // Entered at #1 after the edge that starts an IDLE cycle; returns at the same point of the next IDLE cycle.
  task automatic run_xfer(input bit hold, input bit rnd, input int dly, input logic [7:0] rdv);
    int          w;
    int          cyc;
    logic [15:0] ea;
    logic [7:0]  ed;
    bit          erd;
    w = model_pick();
    if (w < 0) begin
      chk_val("pending_req", 0, 1);
      return;
    end
    ea = m_addr[w]; ed = m_wd[w]; erd = m_rd[w];
    @(negedge clk);
    chk_val("idle_busy", busy, 0);
    chk_val("idle_ack", ack, 0);
    chk_val("idle_cmd", {wr_en, rd_en}, 0);
    cyc = 0;
    while (!i2c_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk_val("start_latency", cyc, 1);
    if (!i2c_start) return;
    chk_val("start_addr", byte_addr, ea);
    chk_val("start_wdata", wr_data, ed);
    chk_val("start_wr_en", wr_en, !erd);
    chk_val("start_rd_en", rd_en, erd);
    chk_val("start_busy", busy, 1);
    m_ptr = w;
    m_pend[w] = 1'b0;
    @(posedge clk); #1;
    if (rnd) begin
      if ($urandom_range(0, 1) == 1) begin
        req[w]              = 1'b0;
        req_addr[16*w +: 16] = 16'($urandom);
        req_wdata[8*w +: 8] = 8'($urandom);
        req_rd[w]           = ~req_rd[w];
      end
      for (int i = 0; i < N; i++)
        if (i != w && !m_pend[i] && $urandom_range(0, 2) == 0)
          post_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    end
    @(negedge clk);
    chk_val("busy_start_low", i2c_start, 0);
    chk_val("busy_addr", byte_addr, ea);
    chk_val("busy_ack", ack, 0);
    if (dly > 1) repeat (dly - 1) @(posedge clk);
    #1;
    i2c_end = 1'b1;
    rd_data = rdv;
    @(posedge clk); #1;
    i2c_end = 1'b0;
    rd_data = 8'($urandom);
    if (erd) m_rdata = rdv;
    @(negedge clk);
    chk_val("done_ack", ack, 32'(1) << w);
    chk_val("done_err", err, 0);
    chk_val("done_rdata", rdata, m_rdata);
    chk_val("done_busy", busy, 1);
    chk_val("done_start", i2c_start, 0);
    chk_val("done_cmd", {byte_addr, wr_en, rd_en}, {ea, !erd, erd});
    @(posedge clk); #1;
    if (hold) m_pend[w] = 1'b1;
    else      req[w] = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_nb;
    int n_ack;
    rst = 1'b1; req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    i2c_end = 1'b0; rd_data = '0;
    clear_model();
    m_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("rst_outs", {ack, err, rdata, busy, i2c_start, wr_en, rd_en}, 0);
    chk_val("rst_cmd", {byte_addr, wr_data}, 0);
    chk_val("rst_addr_num", addr_num, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed write and read
    post_req(0, 1'b0, 16'h3008, 8'h82);
    run_xfer(1'b0, 1'b0, 50, 8'h11);
    post_req(2, 1'b1, 16'h300A, 8'h00);
    run_xfer(1'b0, 1'b0, 10, 8'h56);
    chk_val("read_rdata", rdata, 8'h56);

    // All requesters held continuously: 0,1,2,0,1,2 expected from the model pointer
    post_req(0, 1'b0, 16'h5000, 8'hA0);
    post_req(1, 1'b1, 16'h5001, 8'hA1);
    post_req(2, 1'b0, 16'h5002, 8'hA2);
    for (int t = 0; t < 6; t++) begin
      chk_val("rr_order", model_pick(), t % N);
      run_xfer(1'b1, 1'b0, $urandom_range(1, 12), 8'($urandom));
    end

    // Randomized traffic with mid-transaction perturbation
    for (int t = 0; t < 40; t++) begin
      if (!any_pending())
        post_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      run_xfer(1'b0, 1'b1, $urandom_range(1, 20), 8'($urandom));
    end
    while (any_pending()) run_xfer(1'b0, 1'b0, $urandom_range(1, 5), 8'($urandom));

    // Reset during BUSY aborts with no ack
    post_req(1, 1'b0, 16'h1234, 8'h77);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!i2c_start && cyc < 20);
    chk_val("rst_mid_start", i2c_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    chk_val("rst_mid_busy", busy, 0);
    chk_val("rst_mid_cmd", {wr_en, rd_en, i2c_start}, 0);
    n_ack = 0;
    repeat (5) begin @(negedge clk); if (|ack) n_ack++; end
    chk_val("rst_mid_no_ack", n_ack, 0);
    m_rdata = 8'h00;
    @(posedge clk); #1;

`ifdef SCCB_TIMEOUT_EN
    // Watchdog expiry 101 cycles after START, then completion on the last BUSY cycle
    post_req(0, 1'b1, 16'h3100, 8'h00);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!i2c_start && cyc < 20);
    chk_val("wdt_start", i2c_start, 1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack == '0 && cyc < 300);
    chk_val("wdt_latency", cyc, 101);
    chk_val("wdt_ack", ack, 3'b001);
    chk_val("wdt_err", err, 1);
    chk_val("wdt_rdata", rdata, m_rdata);
    @(posedge clk); #1;
    req[0] = 1'b0; m_pend[0] = 1'b0; m_ptr = 0;
    post_req(1, 1'b1, 16'h3101, 8'h00);
    run_xfer(1'b0, 1'b0, 100, 8'h3C);
`else
    // No watchdog: a silent master keeps the arbiter busy indefinitely
    post_req(2, 1'b1, 16'h3200, 8'h00);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!i2c_start && cyc < 20);
    chk_val("hang_start", i2c_start, 1);
    n_nb = 0; n_ack = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!busy) n_nb++;
      if (|ack) n_ack++;
    end
    chk_val("hang_busy", n_nb, 0);
    chk_val("hang_no_ack", n_ack, 0);
    chk_val("hang_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
